pc_bus_arbiter: RTL

Shares the PC system bus between three masters: the 8088 bus-cycle unit, the DMA controller's hold request, and a built-in DRAM refresh scheduler. It is a single-owner, non-preemptive arbiter with fixed priority and a one-cycle turnaround between owners. It drives the CPU grant, the DMA hold-acknowledge, the refresh grant and the PC address-enable (AEN). It sits between the processor wrapper's bus FSM and the motherboard bus/DMA logic.

---
 rtl/pc_bus_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/pc_bus_arbiter.sv
// -----------------------------------------------------------------------------
// pc_bus_arbiter
//
// Shares the PC system bus between the 8088 bus-cycle unit, the DMA hold
// request and a built-in DRAM refresh scheduler. The arbiter gives the bus to
// one owner at a time and does not preempt the current owner. Priority is
// fixed: refresh first, then DMA, then CPU. Every change of owner passes
// through one turnaround (TURN) cycle and one IDLE cycle.
//
// Parameters
//   REF_PERIOD : clocks between refresh requests (2 .. 2**CNT_W)
//   CNT_W      : width of the refresh interval counter
//
// Ports
//   clk        in   system clock; all state changes on the rising edge
//   rst        in   synchronous, active-high reset
//   cpu_req    in   CPU bus request (level, held until granted)
//   cpu_done   in   one-cycle pulse: CPU bus cycle finished
//   cpu_gnt    out  CPU owns the bus
//   dma_hrq    in   DMA hold request (level, held for the whole ownership)
//   dma_hlda   out  DMA hold acknowledge
//   ref_done   in   one-cycle pulse: refresh cycle finished
//   ref_gnt    out  refresh owns the bus
//   aen        out  address enable; high exactly while dma_hlda is high
//   bus_owner  out  00 none, 01 CPU, 10 DMA, 11 refresh
//   ref_pend   out  a refresh request is outstanding
//   ref_miss   out  saturating count of lost refresh intervals
// -----------------------------------------------------------------------------
module pc_bus_arbiter #(
    parameter int REF_PERIOD = 72,
    parameter int CNT_W      = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_req,
    input  logic       cpu_done,
    output logic       cpu_gnt,
    input  logic       dma_hrq,
    output logic       dma_hlda,
    input  logic       ref_done,
    output logic       ref_gnt,
    output logic       aen,
    output logic [1:0] bus_owner,
    output logic       ref_pend,
    output logic [3:0] ref_miss
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CPU  = 3'd1,
        S_DMA  = 3'd2,
        S_REF  = 3'd3,
        S_TURN = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(REF_PERIOD - 1);
    localparam logic [3:0]       MISS_MAX = 4'd15;

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic             wrap_s;
    logic             enter_ref_s;

    // Bus-owner code shown on bus_owner for a given arbiter state.
    function automatic logic [1:0] owner_code(input state_t st);
        logic [1:0] code;
        case (st)
            S_CPU:   code = 2'b01;
            S_DMA:   code = 2'b10;
            S_REF:   code = 2'b11;
            default: code = 2'b00;
        endcase
        return code;
    endfunction

    assign wrap_s      = (cnt_r == CNT_MAX);
    // Refresh always wins arbitration in IDLE, so a pending refresh seen in
    // IDLE means the REF state is entered at this edge.
    assign enter_ref_s = (state_r == S_IDLE) && ref_pend;

    // Next-state logic: fixed-priority arbitration in IDLE, release handling
    // in the owner states, unconditional TURN -> IDLE.
    always_comb begin
        next_state_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (ref_pend) begin
                    next_state_s = S_REF;
                end else if (dma_hrq) begin
                    next_state_s = S_DMA;
                end else if (cpu_req) begin
                    next_state_s = S_CPU;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_CPU: begin
                if (cpu_done) begin
                    next_state_s = S_TURN;
                end else begin
                    next_state_s = S_CPU;
                end
            end
            S_DMA: begin
                if (!dma_hrq) begin
                    next_state_s = S_TURN;
                end else begin
                    next_state_s = S_DMA;
                end
            end
            S_REF: begin
                if (ref_done) begin
                    next_state_s = S_TURN;
                end else begin
                    next_state_s = S_REF;
                end
            end
            S_TURN:  next_state_s = S_IDLE;
            // An illegal encoding falls back to IDLE with every grant low.
            default: next_state_s = S_IDLE;
        endcase
    end

    // Arbiter state register; grants are registered from the next state so
    // they change on the same edge as the state does.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            cpu_gnt   <= 1'b0;
            dma_hlda  <= 1'b0;
            aen       <= 1'b0;
            ref_gnt   <= 1'b0;
            bus_owner <= 2'b00;
        end else begin
            state_r   <= next_state_s;
            cpu_gnt   <= (next_state_s == S_CPU);
            dma_hlda  <= (next_state_s == S_DMA);
            aen       <= (next_state_s == S_DMA);
            ref_gnt   <= (next_state_s == S_REF);
            bus_owner <= owner_code(next_state_s);
        end
    end

    // Free-running refresh interval counter, 0 .. REF_PERIOD-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (wrap_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Refresh pending flag: a new interval sets it, entering REF clears it;
    // when both happen on one edge the new interval keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_pend <= 1'b0;
        end else if (wrap_s) begin
            ref_pend <= 1'b1;
        end else if (enter_ref_s) begin
            ref_pend <= 1'b0;
        end else begin
            ref_pend <= ref_pend;
        end
    end

    // Lost-interval counter: an interval is lost when a new one arrives while
    // the previous is still pending and not being served at that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_miss <= 4'd0;
        end else if (wrap_s && ref_pend && !enter_ref_s && (ref_miss != MISS_MAX)) begin
            ref_miss <= ref_miss + 4'd1;
        end else begin
            ref_miss <= ref_miss;
        end
    end

endmodule
